// File: rtl/multicycle_alu.sv
// Multicycle signed ALU: single-cycle ADD/SUB and 16-iteration shift-add MUL / restoring DIV,
// handshaken with alu_start/alu_done.
module multicycle_alu #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_start,
  input  logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_result_low,
  output logic [WIDTH-1:0] alu_result_high,
  output logic             alu_done,
  output logic             alu_overflow,
  output logic             alu_div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [2:0]       OP_ADD    = 3'b000;
  localparam logic [2:0]       OP_SUB    = 3'b001;
  localparam logic [4:0]       LAST_ITER = 5'(ITER - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   mag_a_q, mag_b_q;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [4:0]       cnt;

  // |v| kept at WIDTH+1 bits so the most negative operand has an exact magnitude.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -ext : ext;
  endfunction

  logic             start_iter;
  logic [WIDTH:0]   in_mag_a, in_mag_b;
  assign start_iter = (alu_opcode[2:1] == 2'b01);
  assign in_mag_a   = magnitude(alu_a);
  assign in_mag_b   = magnitude(alu_b);

  logic [WIDTH-1:0] add_res, sub_res;
  logic             add_ovf, sub_ovf;
  assign add_res = a_q + b_q;
  assign sub_res = a_q - b_q;
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);

  // MUL step: {acc_hi, acc_lo} holds partial product over the remaining multiplier bits.
  logic [WIDTH+1:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a_q} : '0);

  // DIV step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {1'b0, mag_b_q};
  assign div_ge    = ~div_diff[WIDTH+1];

  logic               res_neg;
  logic [2*WIDTH-1:0] prod_mag, prod_signed;
  logic [WIDTH-1:0]   rem_mag, quot_signed, rem_signed;
  assign res_neg     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign prod_mag    = {acc_hi[WIDTH-1:0], acc_lo};
  assign prod_signed = res_neg ? -prod_mag : prod_mag;
  assign rem_mag     = acc_hi[WIDTH-1:0];
  assign quot_signed = res_neg ? -acc_lo : acc_lo;
  assign rem_signed  = a_q[WIDTH-1] ? -rem_mag : rem_mag;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:   if (alu_start) state_nxt = start_iter ? S_ITER : S_ADDSUB;
      S_ADDSUB: state_nxt = S_DONE;
      S_ITER:   if (cnt == LAST_ITER) state_nxt = S_FIX;
      S_FIX:    state_nxt = S_DONE;
      S_DONE:   if (!alu_start) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q            <= '0;
      a_q             <= '0;
      b_q             <= '0;
      mag_a_q         <= '0;
      mag_b_q         <= '0;
      acc_hi          <= '0;
      acc_lo          <= '0;
      cnt             <= '0;
      alu_result_low  <= '0;
      alu_result_high <= '0;
      alu_done        <= 1'b0;
      alu_overflow    <= 1'b0;
      alu_div_zero    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (alu_start) begin
            op_q    <= alu_opcode;
            a_q     <= alu_a;
            b_q     <= alu_b;
            mag_a_q <= in_mag_a;
            mag_b_q <= in_mag_b;
            acc_hi  <= '0;
            acc_lo  <= alu_opcode[0] ? in_mag_a[WIDTH-1:0] : in_mag_b[WIDTH-1:0];
            cnt     <= '0;
          end
        end
        S_ADDSUB: begin
          alu_done     <= 1'b1;
          alu_div_zero <= 1'b0;
          case (op_q)
            OP_ADD: begin
              alu_result_low  <= add_res;
              alu_result_high <= {WIDTH{add_res[WIDTH-1]}};
              alu_overflow    <= add_ovf;
            end
            OP_SUB: begin
              alu_result_low  <= sub_res;
              alu_result_high <= {WIDTH{sub_res[WIDTH-1]}};
              alu_overflow    <= sub_ovf;
            end
            default: begin
              alu_result_low  <= '0;
              alu_result_high <= '0;
              alu_overflow    <= 1'b0;
            end
          endcase
        end
        S_ITER: begin
          cnt <= cnt + 5'd1;
          if (!op_q[0]) begin
            acc_hi <= mul_sum[WIDTH+1:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end else begin
            acc_hi <= div_ge ? div_diff[WIDTH:0] : div_shift;
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end
        end
        S_FIX: begin
          alu_done <= 1'b1;
          if (!op_q[0]) begin
            {alu_result_high, alu_result_low} <= prod_signed;
            alu_overflow <= 1'b0;
            alu_div_zero <= 1'b0;
          end else if (b_q == '0) begin
            alu_result_low  <= MINUS_ONE;
            alu_result_high <= a_q;
            alu_overflow    <= 1'b0;
            alu_div_zero    <= 1'b1;
          end else begin
            alu_result_low  <= quot_signed;
            alu_result_high <= rem_signed;
            alu_overflow    <= (a_q == MOST_NEG) && (b_q == MINUS_ONE);
            alu_div_zero    <= 1'b0;
          end
        end
        S_DONE: if (!alu_start) alu_done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu: arithmetic corners, latency and handshake.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_start;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result_low, alu_result_high;
  logic        alu_done, alu_overflow, alu_div_zero;

  int n_cmp = 0;
  int n_err = 0;
  int edges;
  logic saw_done;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(16), .ITER(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_start       (alu_start),
    .alu_opcode      (alu_opcode),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_result_low  (alu_result_low),
    .alu_result_high (alu_result_high),
    .alu_done        (alu_done),
    .alu_overflow    (alu_overflow),
    .alu_div_zero    (alu_div_zero)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; counts rising edges until done is seen (bounded).
  // After E0 the operand inputs are scrambled to show they are ignored.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int drop_at, output int n_edges);
    alu_opcode = op;
    alu_a      = a;
    alu_b      = b;
    alu_start  = 1'b1;
    n_edges    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_edges++;
      if (n_edges == 1) begin
        alu_opcode = 3'($urandom);
        alu_a      = 16'($urandom);
        alu_b      = 16'($urandom);
      end
      if (n_edges == drop_at) alu_start = 1'b0;
      if (alu_done) break;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                              input logic ovf, input logic dz, input int lat, input int n_edges);
    check({tag, "_latency"}, 32'(n_edges), 32'(lat));
    check({tag, "_low"}, {16'h0, alu_result_low}, {16'h0, lo});
    check({tag, "_high"}, {16'h0, alu_result_high}, {16'h0, hi});
    check({tag, "_ovf"}, {31'h0, alu_overflow}, {31'h0, ovf});
    check({tag, "_dz"}, {31'h0, alu_div_zero}, {31'h0, dz});
  endtask

  task automatic release_start(input string tag);
    alu_start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clear"}, {31'h0, alu_done}, 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_low"}, {16'h0, alu_result_low}, 32'h0);
    check({tag, "_high"}, {16'h0, alu_result_high}, 32'h0);
    check({tag, "_done"}, {31'h0, alu_done}, 32'h0);
    check({tag, "_ovf"}, {31'h0, alu_overflow}, 32'h0);
    check({tag, "_dz"}, {31'h0, alu_div_zero}, 32'h0);
  endtask

  initial begin
    reset      = 1'b0;
    alu_start  = 1'b0;
    alu_opcode = 3'b000;
    alu_a      = 16'h0;
    alu_b      = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset");

    run_op(OP_ADD, 16'h7FFF, 16'h0001, 0, edges);
    check_result("add_ovf", 16'h8000, 16'hFFFF, 1'b1, 1'b0, 2, edges);
    release_start("add_ovf");

    // Started right after the release edge: accepted after a single IDLE cycle.
    run_op(OP_SUB, 16'h0005, 16'h0009, 0, edges);
    check_result("sub", 16'hFFFC, 16'hFFFF, 1'b0, 1'b0, 2, edges);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done", {31'h0, alu_done}, 32'h1);
      check("hold_low", {16'h0, alu_result_low}, 32'h0000_FFFC);
    end
    release_start("sub");

    run_op(OP_MUL, 16'hFED4, 16'h00FA, 0, edges);
    check_result("mul_m300x250", 16'hDB08, 16'hFFFE, 1'b0, 1'b0, 18, edges);
    release_start("mul_m300x250");

    run_op(OP_MUL, 16'h8000, 16'h8000, 0, edges);
    check_result("mul_minmin", 16'h0000, 16'h4000, 1'b0, 1'b0, 18, edges);
    release_start("mul_minmin");

    run_op(OP_MUL, 16'h007B, 16'hFFD3, 0, edges);
    check_result("mul_123xm45", 16'hEA61, 16'hFFFF, 1'b0, 1'b0, 18, edges);
    release_start("mul_123xm45");

    run_op(OP_DIV, 16'hFFF9, 16'h0002, 0, edges);
    check_result("div_m7d2", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18, edges);
    release_start("div_m7d2");

    run_op(OP_DIV, 16'h03E8, 16'hFFF9, 0, edges);
    check_result("div_1000dm7", 16'hFF72, 16'h0006, 1'b0, 1'b0, 18, edges);
    release_start("div_1000dm7");

    run_op(OP_DIV, 16'h0064, 16'h0000, 0, edges);
    check_result("div_zero", 16'hFFFF, 16'h0064, 1'b0, 1'b1, 18, edges);
    release_start("div_zero");

    run_op(OP_DIV, 16'h8000, 16'hFFFF, 0, edges);
    check_result("div_ovf", 16'h8000, 16'h0000, 1'b1, 1'b0, 18, edges);
    release_start("div_ovf");

    run_op(3'b101, 16'h0005, 16'h0003, 0, edges);
    check_result("invalid", 16'h0000, 16'h0000, 1'b0, 1'b0, 2, edges);
    release_start("invalid");

    // Start dropped so it is sampled low at E3: single-cycle done pulse.
    run_op(OP_MUL, 16'hFED4, 16'h00FA, 3, edges);
    check_result("mul_drop", 16'hDB08, 16'hFFFE, 1'b0, 1'b0, 18, edges);
    @(negedge clk);
    check("mul_drop_pulse", {31'h0, alu_done}, 32'h0);

    // Reset sampled at E5 of a MUL: everything cleared, no done ever appears.
    alu_opcode = OP_MUL;
    alu_a      = 16'h1234;
    alu_b      = 16'h0056;
    alu_start  = 1'b1;
    repeat (5) @(negedge clk);
    reset     = 1'b0;
    alu_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_zero("midop_reset");
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (alu_done) saw_done = 1'b1;
    end
    check("midop_no_done", {31'h0, saw_done}, 32'h0);

    run_op(OP_ADD, 16'h0002, 16'h0003, 0, edges);
    check_result("add_after_reset", 16'h0005, 16'h0000, 1'b0, 1'b0, 2, edges);
    release_start("add_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
